fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 17 +
 rtl/fetch_sequencer_btn_debounce.sv | 58 +++++
 rtl/fetch_sequencer.sv | 148 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer.
//   state_e : sequencer state encoding (IDLE=00, RUN=01, STEP=10, BREAK=11)
//   PC_W    : width of PC values compared against the breakpoint
//   CNT_W   : width of the PCEn strobe counter
package fetch_sequencer_pkg;

    localparam int PC_W  = 32;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_e;

endpackage

// File: rtl/fetch_sequencer_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer followed by a debounce counter.
//   Clk      : system clock
//   Reset    : synchronous active-low reset
//   btn_raw  : asynchronous raw pushbutton
//   step_evt : one-cycle pulse on each accepted 0->1 transition
module btn_debounce #(
    parameter int unsigned DEBOUNCE = 1000000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic btn_raw,
    output logic step_evt
);

    localparam int DB_W = 24;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            evt_q, evt_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // The counter tracks how many consecutive synchronized samples disagree
    // with the accepted level; any agreeing sample restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        evt_d   = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
            evt_d   = sync2_q;
        end else begin
            cnt_d = cnt_q + DB_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            evt_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            evt_q   <= evt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign step_evt = evt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: paces PC advances of a fetch unit in free-run, single-step
// and breakpoint modes.
//   Clk, Reset          : clock, synchronous active-low reset
//   Run, Halt           : level requests (Halt dominates)
//   StepBtn             : raw single-step pushbutton
//   BrkEn, BrkAddr      : breakpoint enable and PC value
//   PCResult            : current PC from the fetch unit
//   PCEn                : one-cycle PC advance strobe
//   FetchRst            : active-high reset to the fetch unit
//   State               : current state encoding
//   StepCount           : PCEn strobes issued since reset (wraps)
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned DEBOUNCE = 1000000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Halt,
    input  logic             StepBtn,
    input  logic             BrkEn,
    input  logic [PC_W-1:0]  BrkAddr,
    input  logic [PC_W-1:0]  PCResult,
    output logic             PCEn,
    output logic             FetchRst,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] StepCount
);

    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

    state_e             state_q, state_d;
    logic [31:0]        tick_q, tick_d;
    logic               pcen_q, pcen_d;
    logic [CNT_W-1:0]   step_count_q, step_count_d;
    logic               fetch_rst_q, fetch_rst_d;
    logic               rst_cnt_q, rst_cnt_d;
    logic               run_low_q, run_low_d;
    logic               step_evt;

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_btn (
        .Clk      (Clk),
        .Reset    (Reset),
        .btn_raw  (StepBtn),
        .step_evt (step_evt)
    );

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        pcen_d      = 1'b0;
        fetch_rst_d = fetch_rst_q;
        rst_cnt_d   = rst_cnt_q;
        run_low_d   = run_low_q;

        if (fetch_rst_q) begin
            // Hold the fetch unit in reset for two cycles after release;
            // the sequencer stays parked in IDLE meanwhile.
            rst_cnt_d = 1'b1;
            if (rst_cnt_q) begin
                fetch_rst_d = 1'b0;
            end
            state_d = ST_IDLE;
            tick_d  = '0;
        end else if (Halt) begin
            state_d = ST_IDLE;
            tick_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Run) begin
                        state_d = ST_RUN;
                        tick_d  = '0;
                    end else if (step_evt) begin
                        state_d = ST_STEP;
                        pcen_d  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!Run) begin
                        state_d = ST_IDLE;
                        tick_d  = '0;
                    end else if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (BrkEn && (PCResult == BrkAddr)) begin
                            state_d   = ST_BREAK;
                            run_low_d = 1'b0;
                        end else begin
                            pcen_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 32'd1;
                    end
                end
                ST_STEP: begin
                    state_d = ST_IDLE;
                end
                ST_BREAK: begin
                    // Resuming needs a fresh Run request: Run must be seen
                    // low at least once after the breakpoint was hit.
                    if (step_evt) begin
                        state_d = ST_STEP;
                        pcen_d  = 1'b1;
                    end else if (Run && run_low_q) begin
                        state_d = ST_RUN;
                        tick_d  = '0;
                    end else if (!Run) begin
                        run_low_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tick_d  = '0;
                end
            endcase
        end

        step_count_d = pcen_d ? step_count_q + CNT_W'(1) : step_count_q;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            pcen_q       <= 1'b0;
            step_count_q <= '0;
            fetch_rst_q  <= 1'b1;
            rst_cnt_q    <= 1'b0;
            run_low_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            pcen_q       <= pcen_d;
            step_count_q <= step_count_d;
            fetch_rst_q  <= fetch_rst_d;
            rst_cnt_q    <= rst_cnt_d;
            run_low_q    <= run_low_d;
        end
    end

    assign PCEn      = pcen_q;
    assign FetchRst  = fetch_rst_q;
    assign State     = state_q;
    assign StepCount = step_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer with TICK_DIV=4, DEBOUNCE=3.
module tb_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Run;
    logic        Halt;
    logic        StepBtn;
    logic        BrkEn;
    logic [31:0] BrkAddr;
    logic [31:0] PCResult;
    logic        PCEn;
    logic        FetchRst;
    logic [1:0]  State;
    logic [15:0] StepCount;

    int errors = 0;
    int checks = 0;

    fetch_sequencer #(.TICK_DIV(4), .DEBOUNCE(3)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Run       (Run),
        .Halt      (Halt),
        .StepBtn   (StepBtn),
        .BrkEn     (BrkEn),
        .BrkAddr   (BrkAddr),
        .PCResult  (PCResult),
        .PCEn      (PCEn),
        .FetchRst  (FetchRst),
        .State     (State),
        .StepCount (StepCount)
    );

    always #5 Clk = ~Clk;

    // Advance one cycle; inputs change and outputs are sampled at negedge.
    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Reset and wait until FetchRst has dropped; FSM is live on the next edge.
    task automatic apply_reset();
        Reset = 1'b0; Run = 1'b0; Halt = 1'b0; StepBtn = 1'b0;
        BrkEn = 1'b0; BrkAddr = '0; PCResult = '0;
        tick(); tick();
        Reset = 1'b1;
        tick(); tick();
    endtask

    // Drive StepBtn from a per-cycle bit pattern and record PCEn/STEP activity.
    task automatic press_and_watch(input logic [31:0] pat, output int pulses,
                                   output int steps, output int first_cyc, output int bad);
        pulses = 0; steps = 0; first_cyc = -1; bad = 0;
        for (int c = 0; c < 24; c++) begin
            StepBtn = pat[c];
            tick();
            if (PCEn === 1'b1) begin
                pulses++;
                if (first_cyc < 0) first_cyc = c;
                if (State !== 2'b10) bad++;
            end
            if (State === 2'b10) steps++;
        end
        StepBtn = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Run = 1'b1; Halt = 1'b0; StepBtn = 1'b0;
        BrkEn = 1'b0; BrkAddr = '0; PCResult = '0;
        tick(); tick(); tick();
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL rst_state got=%0d exp=0", State); end
        checks++; if (PCEn !== 1'b0) begin errors++; $display("FAIL rst_pcen got=%0b exp=0", PCEn); end
        checks++; if (StepCount !== 16'h0) begin errors++; $display("FAIL rst_count got=%0h exp=0", StepCount); end
        checks++; if (FetchRst !== 1'b1) begin errors++; $display("FAIL rst_fetchrst got=%0b exp=1", FetchRst); end
        Reset = 1'b1;
        tick();
        checks++; if (FetchRst !== 1'b1) begin errors++; $display("FAIL fetchrst_c1 got=%0b exp=1", FetchRst); end
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL state_c1 got=%0d exp=0", State); end
        tick();
        checks++; if (FetchRst !== 1'b0) begin errors++; $display("FAIL fetchrst_c2 got=%0b exp=0", FetchRst); end
        checks++; if (PCEn !== 1'b0) begin errors++; $display("FAIL pcen_c2 got=%0b exp=0", PCEn); end
        tick();
        checks++; if (State !== 2'b01) begin errors++; $display("FAIL enter_run got=%0d exp=1", State); end
        for (int k = 1; k <= 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                checks++; if (PCEn !== 1'b0) begin errors++; $display("FAIL run_gap k=%0d i=%0d got=%0b exp=0", k, i, PCEn); end
            end
            tick();
            checks++; if (PCEn !== 1'b1) begin errors++; $display("FAIL run_strobe k=%0d got=%0b exp=1", k, PCEn); end
            checks++; if (StepCount !== 16'(k)) begin errors++; $display("FAIL run_count got=%0d exp=%0d", StepCount, k); end
        end
        Run = 1'b0;
        tick();
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL run_stop got=%0d exp=0", State); end
        $display("test_reset: release, 3 strobes, stop done");
    endtask

    task automatic test_step_debounce();
        int pulses, steps, first_cyc, bad;
        apply_reset();
        // 1,0,1 bounce then 1 held for 5 cycles (bits 0 and 2..6)
        press_and_watch(32'h0000_007D, pulses, steps, first_cyc, bad);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL dbn_pulses got=%0d exp=1", pulses); end
        checks++; if (steps !== 1) begin errors++; $display("FAIL dbn_steps got=%0d exp=1", steps); end
        checks++; if (first_cyc !== 7) begin errors++; $display("FAIL dbn_latency got=%0d exp=7", first_cyc); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL dbn_pcen_not_step got=%0d exp=0", bad); end
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL dbn_final_state got=%0d exp=0", State); end
        checks++; if (StepCount !== 16'd1) begin errors++; $display("FAIL dbn_count got=%0d exp=1", StepCount); end
        $display("test_step_debounce: bounced press done");
    endtask

    task automatic test_break();
        int pulses, steps, first_cyc, bad;
        apply_reset();
        BrkEn = 1'b1; BrkAddr = 32'h8; PCResult = 32'h8; Run = 1'b1;
        tick();
        checks++; if (State !== 2'b01) begin errors++; $display("FAIL brk_enter_run got=%0d exp=1", State); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (PCEn !== 1'b0) begin errors++; $display("FAIL brk_no_pcen i=%0d got=%0b exp=0", i, PCEn); end
        end
        checks++; if (State !== 2'b11) begin errors++; $display("FAIL brk_state got=%0d exp=3", State); end
        checks++; if (StepCount !== 16'd0) begin errors++; $display("FAIL brk_count got=%0d exp=0", StepCount); end
        tick(); tick();
        checks++; if (State !== 2'b11) begin errors++; $display("FAIL brk_hold got=%0d exp=3", State); end
        Run = 1'b0;
        press_and_watch(32'h0000_003F, pulses, steps, first_cyc, bad);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL brk_step_pulses got=%0d exp=1", pulses); end
        checks++; if (first_cyc !== 5) begin errors++; $display("FAIL brk_step_latency got=%0d exp=5", first_cyc); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL brk_pcen_not_step got=%0d exp=0", bad); end
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL brk_final_state got=%0d exp=0", State); end
        checks++; if (StepCount !== 16'd1) begin errors++; $display("FAIL brk_step_count got=%0d exp=1", StepCount); end
        $display("test_break: breakpoint and step-out done");
    endtask

    task automatic test_halt();
        apply_reset();
        Run = 1'b1;
        tick(); tick(); tick(); tick();
        Halt = 1'b1;
        tick();
        checks++; if (PCEn !== 1'b0) begin errors++; $display("FAIL halt_pcen got=%0b exp=0", PCEn); end
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL halt_state got=%0d exp=0", State); end
        tick();
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL halt_hold got=%0d exp=0", State); end
        checks++; if (StepCount !== 16'd0) begin errors++; $display("FAIL halt_count got=%0d exp=0", StepCount); end
        Halt = 1'b0;
        tick();
        checks++; if (State !== 2'b01) begin errors++; $display("FAIL halt_resume got=%0d exp=1", State); end
        Run = 1'b0;
        tick();
        $display("test_halt: halt at terminal count done");
    endtask

    task automatic test_wrap();
        apply_reset();
        force dut.step_count_q = 16'hFFFE;
        tick();
        release dut.step_count_q;
        tick();
        checks++; if (StepCount !== 16'hFFFE) begin errors++; $display("FAIL wrap_preload got=%0h exp=fffe", StepCount); end
        Run = 1'b1;
        tick();
        repeat (4) tick();
        checks++; if (PCEn !== 1'b1) begin errors++; $display("FAIL wrap_strobe1 got=%0b exp=1", PCEn); end
        checks++; if (StepCount !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got=%0h exp=ffff", StepCount); end
        repeat (4) tick();
        checks++; if (PCEn !== 1'b1) begin errors++; $display("FAIL wrap_strobe2 got=%0b exp=1", PCEn); end
        checks++; if (StepCount !== 16'h0000) begin errors++; $display("FAIL wrap_zero got=%0h exp=0", StepCount); end
        Run = 1'b0;
        tick();
        $display("test_wrap: counter wrap done");
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        Run = 1'b1;
        tick();
        repeat (4) tick();
        checks++; if (StepCount !== 16'd1) begin errors++; $display("FAIL mid_pre_count got=%0d exp=1", StepCount); end
        tick(); tick();
        Reset = 1'b0;
        tick();
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL mid_state got=%0d exp=0", State); end
        checks++; if (PCEn !== 1'b0) begin errors++; $display("FAIL mid_pcen got=%0b exp=0", PCEn); end
        checks++; if (StepCount !== 16'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", StepCount); end
        checks++; if (FetchRst !== 1'b1) begin errors++; $display("FAIL mid_fetchrst got=%0b exp=1", FetchRst); end
        tick();
        checks++; if (PCEn !== 1'b0) begin errors++; $display("FAIL mid_pcen2 got=%0b exp=0", PCEn); end
        Reset = 1'b1; Run = 1'b0;
        tick();
        $display("test_reset_mid_run: reset during run done");
    endtask

    initial begin
        Reset = 1'b0; Run = 1'b0; Halt = 1'b0; StepBtn = 1'b0;
        BrkEn = 1'b0; BrkAddr = '0; PCResult = '0;
        @(negedge Clk);
        test_reset();
        test_step_debounce();
        test_break();
        test_halt();
        test_wrap();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
